// File: rtl/display_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_ctrl_pkg
//  Description : Shared command encoding, button indices and command priority
//                for the digit-edit display front-end controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_ctrl_pkg;

    // Command issued to the display register; at most one per cycle.
    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_LOAD  = 3'd1,
        CMD_INC   = 3'd2,
        CMD_DEC   = 3'd3,
        CMD_LEFT  = 3'd4,
        CMD_RIGHT = 3'd5
    } cmd_e;

    // Button indices. The index order is also the arbitration order:
    // a lower index wins over a higher one (CPU load outranks all of them).
    localparam int C_NUM_BTN   = 4;
    localparam int C_BTN_UP    = 0;
    localparam int C_BTN_DOWN  = 1;
    localparam int C_BTN_LEFT  = 2;
    localparam int C_BTN_RIGHT = 3;

    // Command produced by servicing a given button.
    function automatic cmd_e btn_cmd(input int idx);
        cmd_e c;
        case (idx)
            C_BTN_UP:    c = CMD_INC;
            C_BTN_DOWN:  c = CMD_DEC;
            C_BTN_LEFT:  c = CMD_LEFT;
            C_BTN_RIGHT: c = CMD_RIGHT;
            default:     c = CMD_NONE;
        endcase
        return c;
    endfunction

    // Fixed-priority pick: CPU load first, then the lowest requesting index.
    function automatic cmd_e arbitrate(input logic load, input logic [C_NUM_BTN-1:0] req);
        cmd_e c;
        c = CMD_NONE;
        if (load) begin
            c = CMD_LOAD;
        end else begin
            for (int i = C_NUM_BTN - 1; i >= 0; i--) begin
                if (req[i]) c = btn_cmd(i);
            end
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_edit_ctrl_btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : btn_conditioner
//  Description : Two-flop synchroniser, debounce counter and optional
//                auto-repeat timer for one raw push button. Emits a single-cycle
//                event on an accepted press and on every auto-repeat.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic evt
);

    localparam int C_DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int C_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int C_RPT_W   = $clog2(C_RPT_MAX) + 1;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_db;
    logic              r_db_prev;
    logic [C_DB_W-1:0] r_db_cnt;
    logic              w_press;
    logic              w_rpt;

    // Synchronise, debounce, and remember last debounced level for edge detect.
    // The counter clears on reaching its limit, so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_db      <= 1'b0;
            r_db_prev <= 1'b0;
            r_db_cnt  <= '0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;
            if (r_sync2 == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == C_DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_db     <= ~r_db;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + C_DB_W'(1);
            end
        end
    end

    // Only the rising debounced edge is an event; release is silent.
    assign w_press = r_db & ~r_db_prev;

    if (REPEAT_EN) begin : g_repeat
        logic [C_RPT_W-1:0] r_tmr;
        logic               r_first;
        logic [C_RPT_W-1:0] w_thr;
        logic               w_held;

        // First repeat waits the long delay, later ones the short period.
        assign w_thr  = r_first ? C_RPT_W'(REPEAT_DELAY) : C_RPT_W'(REPEAT_PERIOD);
        assign w_held = r_db & r_db_prev;
        assign w_rpt  = w_held && (r_tmr == w_thr);

        // Repeat timer: starts at the press event, restarts on each repeat,
        // clears on release, saturates at the active threshold.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_tmr   <= '0;
                r_first <= 1'b1;
            end else if (w_press) begin
                r_tmr   <= C_RPT_W'(1);
                r_first <= 1'b1;
            end else if (!r_db) begin
                r_tmr   <= '0;
                r_first <= 1'b1;
            end else if (w_rpt) begin
                r_tmr   <= C_RPT_W'(1);
                r_first <= 1'b0;
            end else if (r_tmr < w_thr) begin
                r_tmr   <= r_tmr + C_RPT_W'(1);
            end
        end
    end else begin : g_no_repeat
        assign w_rpt = 1'b0;
    end

    assign evt = w_press | w_rpt;

endmodule
`default_nettype wire

// File: rtl/display_edit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : display_edit_ctrl
//  Description : Front-end controller for the digit-edit display register.
//                Conditions four buttons, latches one pending event per
//                button, arbitrates against a CPU load port and drives
//                one-hot-or-zero command pulses to the register.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_edit_ctrl
    import display_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        cpu_lock,
    input  logic        cpu_wr_req,
    input  logic [15:0] cpu_wr_data,
    output logic        cpu_wr_ack,
    output logic [15:0] disp_D,
    output logic        disp_load,
    output logic        disp_inc,
    output logic        disp_dec,
    output logic        disp_moveLeftDec,
    output logic        disp_moveRightDec
);

    logic [C_NUM_BTN-1:0] w_raw;
    logic [C_NUM_BTN-1:0] w_evt;
    logic [C_NUM_BTN-1:0] w_req;
    logic [C_NUM_BTN-1:0] w_grant;
    logic [C_NUM_BTN-1:0] r_pend;
    logic                 r_req_q;
    logic                 r_wr_block;
    logic                 w_load;
    cmd_e                 w_cmd_nxt;
    cmd_e                 r_cmd;

    assign w_raw[C_BTN_UP]    = btn_up;
    assign w_raw[C_BTN_DOWN]  = btn_down;
    assign w_raw[C_BTN_LEFT]  = btn_left;
    assign w_raw[C_BTN_RIGHT] = btn_right;

    for (genvar i = 0; i < C_NUM_BTN; i++) begin : g_btn
        btn_conditioner #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       ((i == C_BTN_UP) || (i == C_BTN_DOWN))
        ) u_cond (
            .clk     (CLK),
            .rst_n   (RESET_N),
            .btn_raw (w_raw[i]),
            .evt     (w_evt[i])
        );
    end

    // A fresh event is visible to the arbiter in the cycle it occurs, so an
    // uncontested press is serviced without first sitting in the pending bit.
    assign w_req  = r_pend | (w_evt & {C_NUM_BTN{~cpu_lock}});
    // A request is accepted once; it re-arms only after the requester drops it.
    assign w_load = r_req_q & ~r_wr_block;

    // Pick this cycle's command and the button it services.
    always_comb begin
        w_grant   = '0;
        w_cmd_nxt = arbitrate(w_load, w_req);
        for (int i = 0; i < C_NUM_BTN; i++) begin
            w_grant[i] = (w_cmd_nxt == btn_cmd(i));
        end
    end

    // Command register, pending bits, CPU handshake and data register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cmd      <= CMD_NONE;
            r_pend     <= '0;
            r_req_q    <= 1'b0;
            r_wr_block <= 1'b0;
            disp_D     <= 16'h0000;
        end else begin
            r_cmd   <= w_cmd_nxt;
            r_pend  <= w_req & ~w_grant;
            r_req_q <= cpu_wr_req;
            if (w_load) begin
                r_wr_block <= 1'b1;
                disp_D     <= cpu_wr_data;
            end else if (!r_req_q) begin
                r_wr_block <= 1'b0;
            end
        end
    end

    assign disp_load         = (r_cmd == CMD_LOAD);
    assign cpu_wr_ack        = (r_cmd == CMD_LOAD);
    assign disp_inc          = (r_cmd == CMD_INC);
    assign disp_dec          = (r_cmd == CMD_DEC);
    assign disp_moveLeftDec  = (r_cmd == CMD_LEFT);
    assign disp_moveRightDec = (r_cmd == CMD_RIGHT);

endmodule
`default_nettype wire

// File: tb/tb_display_edit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_edit_ctrl
//  Description : Self-checking bench for display_edit_ctrl with
//                DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_edit_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        btn_left, btn_right, btn_up, btn_down;
    logic        cpu_lock, cpu_wr_req;
    logic [15:0] cpu_wr_data;
    logic        cpu_wr_ack;
    logic [15:0] disp_D;
    logic        disp_load, disp_inc, disp_dec, disp_moveLeftDec, disp_moveRightDec;
    logic [4:0]  cmds;

    int n_cmp = 0;
    int n_bad = 0;
    int onehot_bad = 0;

    // Command bits: 4 load, 3 inc, 2 dec, 1 left, 0 right.
    assign cmds = {disp_load, disp_inc, disp_dec, disp_moveLeftDec, disp_moveRightDec};

    display_edit_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (4)
    ) dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .btn_left          (btn_left),
        .btn_right         (btn_right),
        .btn_up            (btn_up),
        .btn_down          (btn_down),
        .cpu_lock          (cpu_lock),
        .cpu_wr_req        (cpu_wr_req),
        .cpu_wr_data       (cpu_wr_data),
        .cpu_wr_ack        (cpu_wr_ack),
        .disp_D            (disp_D),
        .disp_load         (disp_load),
        .disp_inc          (disp_inc),
        .disp_dec          (disp_dec),
        .disp_moveLeftDec  (disp_moveLeftDec),
        .disp_moveRightDec (disp_moveRightDec)
    );

    always #5 CLK = ~CLK;

    // Continuous invariants: never two commands at once, ack mirrors load.
    always @(negedge CLK) begin
        if (RESET_N === 1'b1) begin
            if ($countones(cmds) > 1) onehot_bad++;
            if (cpu_wr_ack !== disp_load) onehot_bad++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One rising edge; inputs are then driven / outputs sampled 1 time unit later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Mask order {up, down, left, right} matches the command bit of each button.
    task automatic set_btns(input logic [3:0] m);
        btn_up    = m[3];
        btn_down  = m[2];
        btn_left  = m[1];
        btn_right = m[0];
    endtask

    typedef struct {
        string       name;
        logic [3:0]  btn;
        int          hold;
        logic [63:0] exp_mask;  // bit e set = target command pulses after edge e
    } vec_t;

    vec_t        vecs[7];
    logic [63:0] obs;
    int          other;
    int          cnt;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Single press scenarios: edge 1 is the first edge that samples raw=1.
        vecs[0] = '{"up_repeat",    4'b1000, 22, (64'd1 << 7) | (64'd1 << 15) | (64'd1 << 19) | (64'd1 << 23) | (64'd1 << 27)};
        vecs[1] = '{"down_repeat",  4'b0100, 22, (64'd1 << 7) | (64'd1 << 15) | (64'd1 << 19) | (64'd1 << 23) | (64'd1 << 27)};
        vecs[2] = '{"left_norep",   4'b0010, 22, (64'd1 << 7)};
        vecs[3] = '{"right_norep",  4'b0001, 22, (64'd1 << 7)};
        vecs[4] = '{"glitch3",      4'b0010, 3,  64'd0};
        vecs[5] = '{"stable4",      4'b0001, 4,  (64'd1 << 7)};
        vecs[6] = '{"up_short",     4'b1000, 12, (64'd1 << 7) | (64'd1 << 15)};

        // Reset with all buttons held.
        RESET_N = 1'b0;
        set_btns(4'hF);
        cpu_lock = 1'b0;
        cpu_wr_req = 1'b0;
        cpu_wr_data = 16'h0000;
        repeat (3) step();
        check("rst_cmds", 64'(cmds), 64'd0);
        check("rst_ack", 64'(cpu_wr_ack), 64'd0);
        check("rst_D", 64'(disp_D), 64'd0);

        // Release reset: inc, dec, left, right on edges 7..10.
        RESET_N = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            logic [4:0] exp;
            step();
            case (e)
                7:       exp = 5'b01000;
                8:       exp = 5'b00100;
                9:       exp = 5'b00010;
                10:      exp = 5'b00001;
                default: exp = 5'b00000;
            endcase
            check($sformatf("release_e%0d", e), 64'(cmds), 64'(exp));
        end
        set_btns(4'h0);
        repeat (30) step();

        // Table-driven single button scenarios.
        for (int v = 0; v < 7; v++) begin
            int idx;
            idx = (vecs[v].btn[3]) ? 3 : (vecs[v].btn[2]) ? 2 : (vecs[v].btn[1]) ? 1 : 0;
            obs = '0;
            other = 0;
            for (int e = 1; e <= 40; e++) begin
                set_btns((e <= vecs[v].hold) ? vecs[v].btn : 4'h0);
                step();
                if (cmds[idx]) obs[e] = 1'b1;
                if ((cmds & ~(5'd1 << idx)) != 5'd0) other++;
            end
            check({vecs[v].name, "_mask"}, obs, vecs[v].exp_mask);
            check({vecs[v].name, "_other"}, 64'(other), 64'd0);
            repeat (10) step();
        end

        // CPU write: req sampled at edge 10, outputs valid after edge 11.
        cpu_wr_data = 16'd1111;
        repeat (9) step();
        cpu_wr_req = 1'b1;
        step();
        check("wr_e10_load", 64'(disp_load), 64'd0);
        step();
        check("wr_e11_cmds", 64'(cmds), 64'b10000);
        check("wr_e11_ack", 64'(cpu_wr_ack), 64'd1);
        check("wr_e11_D", 64'(disp_D), 64'd1111);
        step();
        check("wr_e12_ack", 64'(cpu_wr_ack), 64'd0);
        check("wr_e12_D", 64'(disp_D), 64'd1111);
        cnt = 0;
        for (int e = 0; e < 6; e++) begin
            step();
            if (cpu_wr_ack) cnt++;
        end
        check("wr_hold_noack", 64'(cnt), 64'd0);
        // Drop for one cycle, then a second write is accepted.
        cpu_wr_req = 1'b0;
        step();
        cpu_wr_req = 1'b1;
        cpu_wr_data = 16'hBEEF;
        step();
        step();
        check("wr2_ack", 64'(cpu_wr_ack), 64'd1);
        check("wr2_D", 64'(disp_D), 64'hBEEF);
        cpu_wr_req = 1'b0;
        repeat (5) step();
        check("wr2_D_hold", 64'(disp_D), 64'hBEEF);

        // Collision: down press event and CPU load in the same cycle.
        cpu_wr_data = 16'h00C5;
        set_btns(4'b0100);
        repeat (5) step();
        cpu_wr_req = 1'b1;
        step();
        step();
        check("coll_load", 64'(cmds), 64'b10000);
        check("coll_D", 64'(disp_D), 64'h00C5);
        cpu_wr_req = 1'b0;
        step();
        check("coll_dec", 64'(cmds), 64'b00100);
        set_btns(4'h0);
        step();
        check("coll_quiet", 64'(cmds), 64'd0);
        repeat (15) step();

        // Lock: press while locked, unlock while held -> nothing.
        cpu_lock = 1'b1;
        set_btns(4'b0001);
        cnt = 0;
        for (int e = 0; e < 15; e++) begin
            step();
            if (disp_moveRightDec) cnt++;
        end
        check("lock_held", 64'(cnt), 64'd0);
        cpu_lock = 1'b0;
        cnt = 0;
        for (int e = 0; e < 15; e++) begin
            step();
            if (disp_moveRightDec) cnt++;
        end
        check("unlock_held", 64'(cnt), 64'd0);
        set_btns(4'h0);
        repeat (10) step();
        // A new press after unlock is serviced normally.
        obs = '0;
        for (int e = 1; e <= 12; e++) begin
            set_btns((e <= 6) ? 4'b0001 : 4'h0);
            step();
            if (disp_moveRightDec) obs[e] = 1'b1;
        end
        check("relock_press", obs, 64'd1 << 7);
        repeat (10) step();

        // Reset mid-debounce with up held: D clears, press re-debounces.
        set_btns(4'b1000);
        repeat (3) step();
        RESET_N = 1'b0;
        #1;
        check("midrst_cmds", 64'(cmds), 64'd0);
        check("midrst_D", 64'(disp_D), 64'd0);
        repeat (2) step();
        RESET_N = 1'b1;
        obs = '0;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (disp_inc) obs[e] = 1'b1;
        end
        check("midrst_inc", obs, 64'd1 << 7);
        set_btns(4'h0);
        repeat (15) step();

        check("onehot_ack_invariant", 64'(onehot_bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
